// File: rtl/branch_predict_hazard_unit.sv
// Dynamic branch predictor (PC-indexed 2-bit saturating counters) with control-hazard
// handling: one-shot flush plus a held redirect handshake back to fetch.
module branch_predict_hazard_unit #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter logic [1:0]  CTR_INIT = 2'b01,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_taken,
    input  logic              stall,
    input  logic              resolve_valid,
    input  logic              resolve_is_br,
    input  logic              resolve_uncond,
    input  logic [ADDR_W-1:0] resolve_pc,
    input  logic              resolve_taken,
    input  logic              resolve_pred,
    input  logic [ADDR_W-1:0] resolve_target,
    input  logic [ADDR_W-1:0] resolve_fallthru,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    input  logic              redirect_ack,
    output logic              busy,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_REDIRECT = 1'b1;

    logic [1:0]        ctr_q [ENTRIES];
    logic [0:0]        state_q,     state_d;
    logic              flush_q,     flush_d;
    logic              redir_vld_q, redir_vld_d;
    logic [ADDR_W-1:0] redir_pc_q,  redir_pc_d;
    logic [CNT_W-1:0]  br_cnt_q,    br_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q,  miss_cnt_d;

    logic [IDX_W-1:0]  lu_idx_c;
    logic [IDX_W-1:0]  res_idx_c;
    logic              accept_c;
    logic              cond_br_c;
    logic              mispredict_c;
    logic              redirect_ev_c;
    logic [1:0]        ctr_cur_c;
    logic [1:0]        ctr_upd_c;
    logic              unused_bits_c;

    // Word-aligned PCs: bit 0 carries no information, upper bits alias freely.
    assign lu_idx_c  = lookup_pc[IDX_W:1];
    assign res_idx_c = resolve_pc[IDX_W:1];
    assign unused_bits_c = ^{lookup_pc[ADDR_W-1:IDX_W+1], lookup_pc[0],
                             resolve_pc[ADDR_W-1:IDX_W+1], resolve_pc[0]};

    // An unconditional transfer takes precedence over the conditional-branch flag.
    assign accept_c      = resolve_valid & ~stall & (state_q == S_IDLE);
    assign cond_br_c     = accept_c & resolve_is_br & ~resolve_uncond;
    assign mispredict_c  = cond_br_c & (resolve_taken != resolve_pred);
    assign redirect_ev_c = mispredict_c | (accept_c & resolve_uncond);

    assign pred_taken = ctr_q[lu_idx_c][1];

    always_comb begin
        ctr_cur_c = ctr_q[res_idx_c];
        ctr_upd_c = ctr_cur_c;
        if (resolve_taken) begin
            if (ctr_cur_c != 2'b11) ctr_upd_c = ctr_cur_c + 2'b01;
        end else begin
            if (ctr_cur_c != 2'b00) ctr_upd_c = ctr_cur_c - 2'b01;
        end
    end

    // Counter table; a same-cycle lookup sees the value before this write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (cond_br_c) begin
            ctr_q[res_idx_c] <= ctr_upd_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            flush_q     <= 1'b0;
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
            br_cnt_q    <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
            br_cnt_q    <= br_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_d     = 1'b0;
        redir_vld_d = redir_vld_q;
        redir_pc_d  = redir_pc_q;
        br_cnt_d    = br_cnt_q;
        miss_cnt_d  = miss_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (redirect_ev_c) begin
                    flush_d     = 1'b1;
                    redir_vld_d = 1'b1;
                    redir_pc_d  = (resolve_uncond | resolve_taken) ? resolve_target
                                                                   : resolve_fallthru;
                    state_d     = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (redirect_ack) begin
                    redir_vld_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                redir_vld_d = 1'b0;
            end
        endcase

        // Statistics saturate at all-ones.
        if (cond_br_c && !(&br_cnt_q)) br_cnt_d = br_cnt_q + CNT_W'(1);
        if (mispredict_c && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end

    assign flush          = flush_q;
    assign redirect_valid = redir_vld_q;
    assign redirect_pc    = redir_pc_q;
    assign busy           = (state_q == S_REDIRECT);
    assign br_count       = br_cnt_q;
    assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_hazard_unit.sv
// Self-checking bench for branch_predict_hazard_unit: vector table plus hand sequences,
// with expected register outputs queued at drive time and compared after the edge.
module tb_branch_predict_hazard_unit;

    localparam int unsigned AW = 16;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] lookup_pc;
    logic          pred_taken;
    logic          stall;
    logic          resolve_valid;
    logic          resolve_is_br;
    logic          resolve_uncond;
    logic [AW-1:0] resolve_pc;
    logic          resolve_taken;
    logic          resolve_pred;
    logic [AW-1:0] resolve_target;
    logic [AW-1:0] resolve_fallthru;
    logic          flush;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          redirect_ack;
    logic          busy;
    logic [CW-1:0] br_count;
    logic [CW-1:0] miss_count;

    always #5 clk = ~clk;

    branch_predict_hazard_unit #(
        .ENTRIES(16), .ADDR_W(AW), .CTR_INIT(2'b01), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
        .stall(stall), .resolve_valid(resolve_valid), .resolve_is_br(resolve_is_br),
        .resolve_uncond(resolve_uncond), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_pred(resolve_pred),
        .resolve_target(resolve_target), .resolve_fallthru(resolve_fallthru),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ack(redirect_ack), .busy(busy), .br_count(br_count),
        .miss_count(miss_count)
    );

    typedef struct {
        logic          va, br, un, tk, pr, st, ak;
        logic [AW-1:0] pc, tg, ft, lu;
        logic          ep, ef, erv;
        logic [AW-1:0] erpc;
        logic [CW-1:0] ebr, emiss;
    } vec_t;

    vec_t sb_q[$];
    vec_t tbl[13];
    int   checks = 0;
    int   errors = 0;
    int   step   = 0;

    function automatic vec_t mk(input logic va, br, un, tk, pr, st, ak,
                                input logic [AW-1:0] pc, tg, ft, lu,
                                input logic ep, ef, erv,
                                input logic [AW-1:0] erpc,
                                input int ebr, emiss);
        vec_t v;
        v.va = va; v.br = br; v.un = un; v.tk = tk; v.pr = pr; v.st = st; v.ak = ak;
        v.pc = pc; v.tg = tg; v.ft = ft; v.lu = lu;
        v.ep = ep; v.ef = ef; v.erv = erv; v.erpc = erpc;
        v.ebr = CW'(ebr); v.emiss = CW'(emiss);
        return v;
    endfunction

    function automatic int sat(input int x);
        return (x > 15) ? 15 : x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic idle_inputs();
        resolve_valid = 1'b0; resolve_is_br = 1'b0; resolve_uncond = 1'b0;
        resolve_taken = 1'b0; resolve_pred = 1'b0; stall = 1'b0; redirect_ack = 1'b0;
        resolve_pc = '0; resolve_target = '0; resolve_fallthru = '0;
    endtask

    // Drive one cycle of stimulus, check the pre-edge lookup, queue the post-edge expectation.
    task automatic apply(input vec_t v);
        resolve_valid = v.va; resolve_is_br = v.br; resolve_uncond = v.un;
        resolve_taken = v.tk; resolve_pred = v.pr; stall = v.st; redirect_ack = v.ak;
        resolve_pc = v.pc; resolve_target = v.tg; resolve_fallthru = v.ft;
        lookup_pc = v.lu;
        #1;
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, v.ep});
        sb_q.push_back(v);
    endtask

    task automatic tick();
        vec_t e;
        @(posedge clk);
        #1;
        step++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("flush", {31'd0, flush}, {31'd0, e.ef});
            chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, e.erv});
            chk("busy", {31'd0, busy}, {31'd0, e.erv});
            if (e.erv) chk("redirect_pc", 32'(redirect_pc), 32'(e.erpc));
            chk("br_count", 32'(br_count), 32'(e.ebr));
            chk("miss_count", 32'(miss_count), 32'(e.emiss));
        end
    endtask

    task automatic run(input vec_t v);
        apply(v);
        tick();
    endtask

    initial begin
        // Steady-state vectors: saturation at 3, fallthru redirect, stall, ack in IDLE, jmp.
        tbl[0]  = mk(1,1,0,1,1,0,0, 16'h3004,16'h3010,16'h3006, 16'h3004, 1, 0,0,16'h0000, 2,1);
        tbl[1]  = mk(1,1,0,1,1,0,0, 16'h3004,16'h3010,16'h3006, 16'h3004, 1, 0,0,16'h0000, 3,1);
        tbl[2]  = mk(1,1,0,1,1,0,0, 16'h3004,16'h3010,16'h3006, 16'h3004, 1, 0,0,16'h0000, 4,1);
        tbl[3]  = mk(1,1,0,0,1,0,0, 16'h3004,16'h3010,16'h3006, 16'h3004, 1, 1,1,16'h3006, 5,2);
        tbl[4]  = mk(0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0000, 16'h3004, 1, 0,0,16'h0000, 5,2);
        tbl[5]  = mk(1,1,0,0,1,0,0, 16'h3004,16'h3010,16'h3006, 16'h3004, 1, 1,1,16'h3006, 6,3);
        tbl[6]  = mk(0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0000, 16'h3004, 0, 0,0,16'h0000, 6,3);
        tbl[7]  = mk(1,1,0,1,1,0,0, 16'h3008,16'h3020,16'h300A, 16'h3008, 0, 0,0,16'h0000, 7,3);
        tbl[8]  = mk(1,1,0,1,0,1,0, 16'h3004,16'h3010,16'h3006, 16'h3008, 1, 0,0,16'h0000, 7,3);
        tbl[9]  = mk(0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0000, 16'h3004, 0, 0,0,16'h0000, 7,3);
        tbl[10] = mk(1,1,1,1,1,0,0, 16'h3004,16'h4000,16'h3006, 16'h3004, 0, 1,1,16'h4000, 7,3);
        tbl[11] = mk(1,1,0,0,1,0,0, 16'h3008,16'h3020,16'h300A, 16'h3004, 0, 0,1,16'h4000, 7,3);
        tbl[12] = mk(0,0,0,0,0,0,0, 16'h0000,16'h0000,16'h0000, 16'h3008, 1, 0,1,16'h4000, 7,3);

        reset_n = 1'b0;
        lookup_pc = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;

        // Reset state: weakly not-taken everywhere, including aliased upper PCs.
        for (int i = 0; i < 32; i++) begin
            lookup_pc = AW'(i * 2 + ((i >= 16) ? 16'h7FE0 : 16'h0000));
            #1;
            chk("reset pred_taken", {31'd0, pred_taken}, 32'd0);
        end
        chk("reset flush", {31'd0, flush}, 32'd0);
        chk("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("reset redirect_pc", 32'(redirect_pc), 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset br_count", 32'(br_count), 32'd0);
        chk("reset miss_count", 32'(miss_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Taken mispredict, redirect held three cycles without ack, then released.
        run(mk(1,1,0,1,0,0,0, 16'h3004,16'h3010,16'h3006, 16'h3004, 0, 1,1,16'h3010, 1,1));
        for (int i = 0; i < 3; i++) begin
            run(mk(0,0,0,0,0,0,0, 16'h0000,16'h0000,16'h0000, 16'h3004, 1, 0,1,16'h3010, 1,1));
        end
        run(mk(0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0000, 16'h3004, 1, 0,0,16'h0000, 1,1));

        for (int i = 0; i < 13; i++) run(tbl[i]);

        // Asynchronous reset while a redirect is still pending.
        reset_n = 1'b0;
        idle_inputs();
        #1;
        chk("async redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("async flush", {31'd0, flush}, 32'd0);
        chk("async busy", {31'd0, busy}, 32'd0);
        chk("async br_count", 32'(br_count), 32'd0);
        chk("async miss_count", 32'(miss_count), 32'd0);
        lookup_pc = 16'h3004;
        #1;
        chk("async pred 3004", {31'd0, pred_taken}, 32'd0);
        lookup_pc = 16'h3008;
        #1;
        chk("async pred 3008", {31'd0, pred_taken}, 32'd0);
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Same-cycle lookup/update returns the old prediction; new value next cycle.
        run(mk(1,1,0,1,0,0,0, 16'h3008,16'h3020,16'h300A, 16'h3008, 0, 1,1,16'h3020, 1,1));
        run(mk(0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0000, 16'h3008, 1, 0,0,16'h0000, 1,1));
        // One-cycle redirect (ack already high), then back-to-back redirect.
        run(mk(1,0,1,0,0,0,1, 16'h3100,16'h5000,16'h3102, 16'h3008, 1, 1,1,16'h5000, 1,1));
        run(mk(0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0000, 16'h3100, 0, 0,0,16'h0000, 1,1));
        run(mk(1,0,1,0,0,0,0, 16'h3200,16'h5100,16'h3202, 16'h3008, 1, 1,1,16'h5100, 1,1));
        run(mk(0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0000, 16'h3008, 1, 0,0,16'h0000, 1,1));
        // Counter saturates at 0: two not-taken, then one taken still predicts not-taken.
        run(mk(1,1,0,0,0,0,0, 16'h300A,16'h3040,16'h300C, 16'h300A, 0, 0,0,16'h0000, 2,1));
        run(mk(1,1,0,0,0,0,0, 16'h300A,16'h3040,16'h300C, 16'h300A, 0, 0,0,16'h0000, 3,1));
        run(mk(1,1,0,1,0,0,0, 16'h300A,16'h3040,16'h300C, 16'h300A, 0, 1,1,16'h3040, 4,2));
        run(mk(0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0000, 16'h300A, 0, 0,0,16'h0000, 4,2));

        // Statistic counters saturate instead of wrapping.
        for (int k = 1; k <= 20; k++) begin
            run(mk(1,1,0,0,0,0,0, 16'h300C,16'h3050,16'h300E, 16'h300C, 0, 0,0,16'h0000,
                   sat(4 + k), 2));
        end
        for (int k = 1; k <= 20; k++) begin
            run(mk(1,1,0,1,0,0,0, 16'h300E,16'h3060,16'h3010, 16'h300E, (k > 1), 1,1,16'h3060,
                   15, sat(2 + k)));
            run(mk(0,0,0,0,0,0,1, 16'h0000,16'h0000,16'h0000, 16'h300E, 1, 0,0,16'h0000,
                   15, sat(2 + k)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_hazard_unit.md
Name: branch_predict_hazard_unit

Overview:
- Dynamic branch-prediction and control-hazard unit. It replaces static predict-not-taken handling of conditional branches.
- Holds a PC-indexed table of 2-bit saturating counters. Fetch queries the table; the resolve stage updates it.
- Detects mispredicts and unconditional control transfers, then drives a one-shot flush and a held redirect handshake to fetch.
- Keeps branch and mispredict statistics.

Parameters:
ENTRIES, 16, number of counter entries; must be a power of two, minimum 2
ADDR_W, 16, PC width
CTR_INIT, 2'b01, counter value loaded at reset (weakly not-taken)
CNT_W, 16, width of statistic counters

Ports:
clk  in  1  clock
reset_n  in  1  reset
lookup_pc  in  ADDR_W  fetch-stage PC
pred_taken  out  1  prediction for lookup_pc
stall  in  1  pipeline load deasserted; resolve inputs are ignored while high
resolve_valid  in  1  resolve stage holds a live instruction
resolve_is_br  in  1  conditional branch (nzp != 000)
resolve_uncond  in  1  jmp/jsr/trap
resolve_pc  in  ADDR_W  PC of the resolving instruction
resolve_taken  in  1  actual branch outcome
resolve_pred  in  1  pred_taken value carried down the pipe with the instruction
resolve_target  in  ADDR_W  taken / jump target
resolve_fallthru  in  ADDR_W  PC+2 of the resolving instruction
flush  out  1  one-cycle squash of younger stages
redirect_valid  out  1  fetch must load redirect_pc
redirect_pc  out  ADDR_W  corrected fetch address
redirect_ack  in  1  fetch has loaded redirect_pc
busy  out  1  high in state REDIRECT
br_count  out  CNT_W  conditional branches resolved
miss_count  out  CNT_W  mispredicts

Behaviour:
- Clock is clk. Reset is reset_n: asynchronous, active-low.
- Reset values:
  - every counter = CTR_INIT
  - state = IDLE
  - flush = 0, redirect_valid = 0, redirect_pc = 0
  - br_count = 0, miss_count = 0
- Index: idx(pc) = pc[IDX_W:1], where IDX_W = log2(ENTRIES). Bit 0 is ignored (word-aligned instructions). No tags, so aliasing is permitted.
- Lookup: pred_taken = table[idx(lookup_pc)][1]. Purely combinational, zero latency.
- Lookup in the same cycle as an update to the same index returns the pre-update value (no bypass).
- Accept condition: accept = resolve_valid & !stall & state == IDLE.
- Table update, on accept & resolve_is_br, at the clock edge:
  - taken: counter increments, saturating at 3
  - not taken: counter decrements, saturating at 0
  - resolve_uncond never updates the table.
- Mispredict: accept & resolve_is_br & (resolve_taken != resolve_pred).
- Redirect event: mispredict, or accept & resolve_uncond.
  - If both resolve_is_br and resolve_uncond are set, resolve_uncond wins and there is no table update.
- FSM IDLE:
  - On a redirect event, the next edge registers:
    - flush = 1
    - redirect_valid = 1
    - redirect_pc = resolve_target if (uncond or resolve_taken), else resolve_fallthru
  - Then go to REDIRECT. Otherwise flush = 0.
- FSM REDIRECT:
  - flush = 0 after the first cycle, so flush is exactly one cycle wide.
  - redirect_valid and redirect_pc are held stable until redirect_ack is sampled high.
  - On that edge: redirect_valid = 0, go to IDLE.
  - All resolve inputs are ignored in REDIRECT (younger instructions are squashed): no table update, no counting.
- Latency:
  - flush and redirect_valid rise 1 cycle after the accepting edge.
  - Minimum redirect duration is 1 cycle, when redirect_ack is already high in the first REDIRECT cycle.
  - A new redirect can be accepted in the cycle after returning to IDLE.
- Statistics:
  - br_count increments on accept & resolve_is_br & !resolve_uncond.
  - miss_count increments on mispredict.
  - Both saturate at all-ones (no wrap).
- redirect_ack while in IDLE is ignored.
- Reset asserted mid-REDIRECT: outputs drop asynchronously and the table returns to CTR_INIT.

Test Plan:
1. Reset, ENTRIES=16 → pred_taken=0 for every lookup_pc; br_count=0; miss_count=0; flush=0.
2. Resolve br at pc=0x3004, taken, resolve_pred=0, target 0x3010 → next cycle flush=1 (1 cycle), redirect_valid=1, redirect_pc=0x3010; held for 3 cycles with redirect_ack=0; release on ack; miss_count=1; then lookup 0x3004 gives pred_taken=1 (counter=2).
3. Same pc resolved taken 3×, then not-taken with pred=1 → counter 3→2, redirect_pc=fallthru 0x3006; pred_taken stays 1; a further not-taken gives 0.
4. Resolve br taken with pred=1 → no flush, br_count+1, miss_count unchanged. Same inputs with stall=1 → no update, no count.
5. Uncond jmp target 0x4000 with resolve_is_br=1 → redirect_pc=0x4000, table entry unchanged. A second resolve_valid during REDIRECT is ignored.
6. reset_n low mid-REDIRECT → redirect_valid=0 immediately, state IDLE, pc 0x3004 predicts 0. Also: lookup and update of pc 0x3008 in the same cycle → old prediction returned.
